// File: rtl/div_request_sequencer.sv
// Front-end sequencer for the free-running iterative divider: holds operands until the
// divider's load point, captures its result, and handles divide-by-zero locally.
//
// state | meaning
// IDLE  | no request held, ready to accept
// ISSUE | operands on Div*, waiting for divider load point
// WAIT  | divider busy, waiting for its result
// DONE  | result presented on Out*, waiting for OutReady
module div_request_sequencer #(
  parameter int INPUT_BIT_WIDTH = 8
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic                       InSign,
  input  logic [INPUT_BIT_WIDTH-1:0] InDividend,
  input  logic [INPUT_BIT_WIDTH-1:0] InDivider,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [INPUT_BIT_WIDTH-1:0] OutQuotient,
  output logic [INPUT_BIT_WIDTH-1:0] OutRemainder,
  output logic                       OutDivByZero,
  output logic                       OutOverflow,
  output logic                       DivSign,
  output logic [INPUT_BIT_WIDTH-1:0] DivDividend,
  output logic [INPUT_BIT_WIDTH-1:0] DivDivider,
  input  logic [INPUT_BIT_WIDTH-1:0] DivQuotient,
  input  logic [INPUT_BIT_WIDTH-1:0] DivRemainder,
  input  logic                       DivReady
);

  localparam int W = INPUT_BIT_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   state;
  logic         op_sign;
  logic [W-1:0] op_dividend;
  logic [W-1:0] op_divider;
  logic         ovf_pend;
  logic         accept;
  logic         div_zero;
  logic         ovf_in;

  assign InReady  = (state == IDLE) || ((state == DONE) && OutReady);
  assign accept   = InValid && InReady;
  assign div_zero = (InDivider == '0);
  assign ovf_in   = InSign && (InDividend == MOST_NEG) && (InDivider == '1);

  // Operand registers feed the divider directly; they only move on accept.
  assign DivSign     = op_sign;
  assign DivDividend = op_dividend;
  assign DivDivider  = op_divider;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      op_sign      <= 1'b0;
      op_dividend  <= '0;
      op_divider   <= '0;
      ovf_pend     <= 1'b0;
      OutValid     <= 1'b0;
      OutQuotient  <= '0;
      OutRemainder <= '0;
      OutDivByZero <= 1'b0;
      OutOverflow  <= 1'b0;
    end else if (accept) begin
      op_sign     <= InSign;
      op_dividend <= InDividend;
      op_divider  <= InDivider;
      ovf_pend    <= ovf_in;
      if (div_zero) begin
        state        <= DONE;
        OutValid     <= 1'b1;
        OutQuotient  <= '1;
        OutRemainder <= InDividend;
        OutDivByZero <= 1'b1;
        OutOverflow  <= 1'b0;
      end else begin
        state    <= ISSUE;
        OutValid <= 1'b0;
      end
    end else begin
      case (state)
        ISSUE: if (DivReady) state <= WAIT;
        // The divider also reloads the held operands at this edge; that result is never used.
        WAIT: if (DivReady) begin
          state        <= DONE;
          OutValid     <= 1'b1;
          OutQuotient  <= DivQuotient;
          OutRemainder <= DivRemainder;
          OutDivByZero <= 1'b0;
          OutOverflow  <= ovf_pend;
        end
        DONE: if (OutReady) begin
          state    <= IDLE;
          OutValid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_request_sequencer.sv
// Directed bench for div_request_sequencer with a free-running divider model (W=8).
module tb_div_request_sequencer;

  localparam int W = 8;

  logic         Clk;
  logic         Rst_n;
  logic         InValid;
  logic         InReady;
  logic         InSign;
  logic [W-1:0] InDividend;
  logic [W-1:0] InDivider;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] OutQuotient;
  logic [W-1:0] OutRemainder;
  logic         OutDivByZero;
  logic         OutOverflow;
  logic         DivSign;
  logic [W-1:0] DivDividend;
  logic [W-1:0] DivDivider;
  logic [W-1:0] DivQuotient;
  logic [W-1:0] DivRemainder;
  logic         DivReady;

  int n_vec  = 0;
  int n_miss = 0;
  int lat;
  int cnt;

  div_request_sequencer #(.INPUT_BIT_WIDTH(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .InValid(InValid), .InReady(InReady), .InSign(InSign),
    .InDividend(InDividend), .InDivider(InDivider),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutQuotient(OutQuotient), .OutRemainder(OutRemainder),
    .OutDivByZero(OutDivByZero), .OutOverflow(OutOverflow),
    .DivSign(DivSign), .DivDividend(DivDividend), .DivDivider(DivDivider),
    .DivQuotient(DivQuotient), .DivRemainder(DivRemainder), .DivReady(DivReady)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Free-running divider: loads on every edge it is ready, then busy for W edges.
  function automatic logic [2*W-1:0] golden(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib, q, r;
    logic [31:0] qv, rv;
    if (b == '0) return {{W{1'b1}}, a};
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    q  = ia / ib;
    r  = ia % ib;
    qv = q;
    rv = r;
    return {qv[W-1:0], rv[W-1:0]};
  endfunction

  initial begin
    DivReady     = 1'b1;
    DivQuotient  = '0;
    DivRemainder = '0;
    cnt          = 0;
  end

  always @(posedge Clk) begin
    if (DivReady) begin
      {DivQuotient, DivRemainder} <= golden(DivSign, DivDividend, DivDivider);
      DivReady <= 1'b0;
      cnt      <= W;
    end else begin
      if (cnt == 1) DivReady <= 1'b1;
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic send(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    InSign     = s;
    InDividend = a;
    InDivider  = b;
    InValid    = 1'b1;
    while (!InReady && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    chk("accept_timeout", (guard < 50) ? 32'd1 : 32'd0, 32'd1);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    while (!OutValid && l < 40) begin
      @(posedge Clk);
      #1;
      l++;
    end
  endtask

  task automatic retire();
    @(negedge Clk);
    OutReady = 1'b1;
    @(posedge Clk);
    #1;
    OutReady = 1'b0;
    chk("retire_valid", OutValid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    Rst_n = 1'b0; InValid = 1'b0; InSign = 1'b0;
    InDividend = '0; InDivider = '0; OutReady = 1'b0;
    repeat (3) @(negedge Clk);

    chk("rst_inready",  InReady, 1);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_quot",     OutQuotient, 0);
    chk("rst_rem",      OutRemainder, 0);
    chk("rst_flags",    {OutDivByZero, OutOverflow}, 0);
    chk("rst_div",      {DivSign, DivDividend, DivDivider}, 0);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Align so the divider is ready on the edge right after accept.
    guard = 0;
    while (!DivReady && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    repeat (W) @(negedge Clk);
    send(1'b0, 8'd200, 8'd7);
    wait_valid(lat);
    chk("u200_7_latency", lat, 10);
    chk("u200_7_quot",  OutQuotient, 28);
    chk("u200_7_rem",   OutRemainder, 4);
    chk("u200_7_flags", {OutDivByZero, OutOverflow}, 0);
    retire();

    @(negedge Clk);
    send(1'b1, 8'h9C, 8'h07);
    wait_valid(lat);
    chk("sneg100_7_valid", OutValid, 1);
    chk("sneg100_7_quot",  OutQuotient, 8'hF2);
    chk("sneg100_7_rem",   OutRemainder, 8'hFE);
    chk("sneg100_7_flags", {OutDivByZero, OutOverflow}, 0);
    retire();

    @(negedge Clk);
    send(1'b0, 8'd55, 8'd0);
    chk("div0_valid_next", OutValid, 1);
    chk("div0_quot",  OutQuotient, 8'hFF);
    chk("div0_rem",   OutRemainder, 55);
    chk("div0_flags", {OutDivByZero, OutOverflow}, 2'b10);
    retire();

    @(negedge Clk);
    send(1'b1, 8'h80, 8'hFF);
    wait_valid(lat);
    chk("ovf_valid", OutValid, 1);
    chk("ovf_quot",  OutQuotient, 8'h80);
    chk("ovf_rem",   OutRemainder, 0);
    chk("ovf_flags", {OutDivByZero, OutOverflow}, 2'b01);

    // Backpressure with a pending request waiting upstream.
    @(negedge Clk);
    InSign = 1'b0; InDividend = 8'd100; InDivider = 8'd9; InValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold", {InReady, OutValid, OutOverflow, OutQuotient, OutRemainder},
          {1'b0, 1'b1, 1'b1, 8'h80, 8'h00});
      @(negedge Clk);
    end
    OutReady = 1'b1;
    @(posedge Clk);
    #1;
    OutReady = 1'b0;
    InValid  = 1'b0;
    chk("b2b_retired",  OutValid, 0);
    chk("b2b_accepted", InReady, 0);
    wait_valid(lat);
    chk("b2b_valid", OutValid, 1);
    chk("b2b_quot",  OutQuotient, 11);
    chk("b2b_rem",   OutRemainder, 1);
    chk("b2b_flags", {OutDivByZero, OutOverflow}, 0);
    retire();

    // Reset while the divider is working on a request.
    @(negedge Clk);
    send(1'b0, 8'd100, 8'd3);
    guard = 0;
    @(negedge Clk);
    while (!DivReady && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    @(negedge Clk);
    @(negedge Clk);
    chk("wait_busy", {OutValid, InReady}, 0);
    Rst_n = 1'b0;
    #1;
    chk("midrst_inready",  InReady, 1);
    chk("midrst_outvalid", OutValid, 0);
    chk("midrst_quot",     OutQuotient, 0);
    chk("midrst_rem",      OutRemainder, 0);
    chk("midrst_div",      {DivSign, DivDividend, DivDivider}, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    send(1'b0, 8'd9, 8'd3);
    wait_valid(lat);
    chk("r9_3_valid", OutValid, 1);
    chk("r9_3_quot",  OutQuotient, 3);
    chk("r9_3_rem",   OutRemainder, 0);
    chk("r9_3_flags", {OutDivByZero, OutOverflow}, 0);
    retire();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
